// File: rtl/lc3_mem_ctrl_pkg.sv
// Shared definitions for the LC-3 memory responder: memory-mapped register
// addresses, R.W encodings, the access FSM state type and the address decoder.
package lc3_mem_ctrl_pkg;

    localparam logic [15:0] KBSR_ADDR = 16'hFE00;
    localparam logic [15:0] KBDR_ADDR = 16'hFE02;
    localparam logic [15:0] DSR_ADDR  = 16'hFE04;
    localparam logic [15:0] DDR_ADDR  = 16'hFE06;

    localparam logic MEM_RD = 1'b0;
    localparam logic MEM_WR = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } mem_state_t;

    // Target of an access: the word RAM or one of the device registers.
    typedef enum logic [2:0] {
        SEL_RAM,
        SEL_KBSR,
        SEL_KBDR,
        SEL_DSR,
        SEL_DDR
    } mem_sel_t;

    function automatic mem_sel_t decode_addr(input logic [15:0] addr);
        mem_sel_t sel;
        case (addr)
            KBSR_ADDR: sel = SEL_KBSR;
            KBDR_ADDR: sel = SEL_KBDR;
            DSR_ADDR:  sel = SEL_DSR;
            DDR_ADDR:  sel = SEL_DDR;
            default:   sel = SEL_RAM;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/lc3_mmio_regs.sv
// Keyboard and display device registers (KBSR/KBDR/DSR/DDR) with their
// handshakes and the register read mux.
//   clk, rst_n        : clock, asynchronous active-low reset
//   wr_en, rd_done    : write / read access in its final (DONE) cycle
//   acc_sel           : register targeted by the access in DONE
//   wr_ie, wr_char    : write data bit 14 and bits 7:0
//   rd_sel, rd_data   : read mux select and result (0 for RAM / DDR)
//   kb_*              : keyboard character input handshake, kb_irq request
//   disp_*            : display character output handshake
module lc3_mmio_regs
    import lc3_mem_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic       rd_done,
    input  mem_sel_t   acc_sel,
    input  logic       wr_ie,
    input  logic [7:0] wr_char,
    input  mem_sel_t   rd_sel,
    output logic [15:0] rd_data,
    input  logic       kb_valid,
    input  logic [7:0] kb_data,
    output logic       kb_ready,
    output logic       kb_irq,
    output logic       disp_valid,
    output logic [7:0] disp_data,
    input  logic       disp_ready
);

    logic       kbsr_rdy;
    logic       kbsr_ie;
    logic [7:0] kbdr;
    logic       dsr_rdy;
    logic       dsr_ie;
    logic [7:0] ddr;

    assign kb_ready   = !kbsr_rdy;
    assign kb_irq     = kbsr_rdy & kbsr_ie;
    assign disp_valid = !dsr_rdy;
    assign disp_data  = ddr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kbsr_rdy <= 1'b0;
            kbsr_ie  <= 1'b0;
            kbdr     <= 8'h00;
            dsr_rdy  <= 1'b1;
            dsr_ie   <= 1'b0;
            ddr      <= 8'h00;
        end else begin
            if (kb_valid && !kbsr_rdy) begin
                kbdr     <= kb_data;
                kbsr_rdy <= 1'b1;
            end
            // Clear-on-read happens while kbsr_rdy=1, so kb_ready is already
            // low that cycle and a new character waits one more cycle.
            if (rd_done && acc_sel == SEL_KBDR) begin
                kbsr_rdy <= 1'b0;
            end

            if (disp_ready && !dsr_rdy) begin
                dsr_rdy <= 1'b1;
            end

            if (wr_en) begin
                case (acc_sel)
                    SEL_KBSR: kbsr_ie <= wr_ie;
                    SEL_DSR:  dsr_ie  <= wr_ie;
                    SEL_DDR: begin
                        ddr     <= wr_char;
                        dsr_rdy <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rd_data = 16'h0000;
        case (rd_sel)
            SEL_KBSR: rd_data = {kbsr_rdy, kbsr_ie, 14'b0};
            SEL_KBDR: rd_data = {8'h00, kbdr};
            SEL_DSR:  rd_data = {dsr_rdy, dsr_ie, 14'b0};
            default:  rd_data = 16'h0000;
        endcase
    end

endmodule

// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory responder: slave end of the MAR/MDR interface. Serves a word
// RAM plus the keyboard/display registers; each access finishes LATENCY
// cycles after it is accepted, signalled by a one-cycle mem_r pulse.
//   clk, rst_n            : clock, asynchronous active-low reset
//   mem_en, mem_rw        : access request and direction (1 = write)
//   mar, mdr_in           : access address and write data
//   mem_data, mem_r       : registered read data, ready pulse
//   kb_valid/kb_data/kb_ready, kb_irq        : keyboard side
//   disp_valid/disp_data/disp_ready          : display side
module lc3_mem_ctrl
    import lc3_mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned LATENCY = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_en,
    input  logic        mem_rw,
    input  logic [15:0] mar,
    input  logic [15:0] mdr_in,
    output logic [15:0] mem_data,
    output logic        mem_r,
    input  logic        kb_valid,
    input  logic [7:0]  kb_data,
    output logic        kb_ready,
    output logic        disp_valid,
    output logic [7:0]  disp_data,
    input  logic        disp_ready,
    output logic        kb_irq
);

    localparam int unsigned DEPTH  = 2 ** ADDR_W;
    localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

    mem_state_t  state;
    logic [3:0]  cnt;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic        rw_q;

    logic [15:0] ram [DEPTH];

    logic [15:0] rd_addr;
    mem_sel_t    rd_sel;
    mem_sel_t    acc_sel;
    logic [15:0] ram_rdata;
    logic [15:0] mmio_rdata;
    logic [15:0] read_val;
    logic        in_done;
    logic        ram_we;

    // With LATENCY=1 DONE is entered straight from IDLE, before the address
    // has been captured, so the read path looks at mar directly then.
    assign rd_addr   = (state == IDLE) ? mar : addr_q;
    assign rd_sel    = decode_addr(rd_addr);
    assign acc_sel   = decode_addr(addr_q);
    assign ram_rdata = ram[rd_addr[ADDR_W-1:0]];
    assign read_val  = (rd_sel == SEL_RAM) ? ram_rdata : mmio_rdata;

    assign in_done = (state == DONE);
    assign ram_we  = in_done && (rw_q == MEM_WR) && (acc_sel == SEL_RAM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            addr_q   <= 16'h0000;
            wdata_q  <= 16'h0000;
            rw_q     <= MEM_RD;
            mem_r    <= 1'b0;
            mem_data <= 16'h0000;
        end else begin
            mem_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_en) begin
                        addr_q  <= mar;
                        rw_q    <= mem_rw;
                        wdata_q <= mdr_in;
                        cnt     <= LAT_M1;
                        if (LATENCY == 1) begin
                            state    <= DONE;
                            mem_r    <= 1'b1;
                            mem_data <= read_val;
                        end else begin
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state    <= DONE;
                        mem_r    <= 1'b1;
                        mem_data <= read_val;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // RAM contents are deliberately not reset; the write lands on the edge
    // that ends DONE, so a reset during BUSY discards it.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[addr_q[ADDR_W-1:0]] <= wdata_q;
        end
    end

    lc3_mmio_regs u_mmio (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (in_done && (rw_q == MEM_WR)),
        .rd_done    (in_done && (rw_q == MEM_RD)),
        .acc_sel    (acc_sel),
        .wr_ie      (wdata_q[14]),
        .wr_char    (wdata_q[7:0]),
        .rd_sel     (rd_sel),
        .rd_data    (mmio_rdata),
        .kb_valid   (kb_valid),
        .kb_data    (kb_data),
        .kb_ready   (kb_ready),
        .kb_irq     (kb_irq),
        .disp_valid (disp_valid),
        .disp_data  (disp_data),
        .disp_ready (disp_ready)
    );

endmodule

// File: doc/lc3_mem_ctrl.md
# lc3_mem_ctrl

Memory responder for the LC-3 datapath: the slave end of the MAR/MDR memory interface driven by the control FSM (MEM.EN, R.W, R). It holds a parameterized word RAM plus the memory-mapped keyboard and display registers (KBSR/KBDR/DSR/DDR). Each access completes after a fixed, configurable latency and is signalled with a one-cycle ready pulse, so the control FSM's wait-for-R loop is exercised.

## Interface
Parameters:
- ADDR_W, 12: RAM index width; RAM depth is 2^ADDR_W words of 16 bits.
- LATENCY, 3: cycles from request to ready pulse; legal range 1..15.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- mem_en  in  1  access request (MEM.EN), held high until mem_r is seen.
- mem_rw  in  1  1 = write, 0 = read (R.W).
- mar  in  16  access address.
- mdr_in  in  16  write data.
- mem_data  out  16  read data; valid only while mem_r=1.
- mem_r  out  1  ready pulse (R), exactly one cycle per access.
- kb_valid  in  1  keyboard character offered.
- kb_data  in  8  keyboard character.
- kb_ready  out  1  keyboard handshake accept; equals !KBSR[15].
- disp_valid  out  1  display character pending; equals !DSR[15].
- disp_data  out  8  DDR[7:0].
- disp_ready  in  1  display consumed the character.
- kb_irq  out  1  KBSR[15] & KBSR[14].

## Operation
- Address decode: xFE00 KBSR, xFE02 KBDR, xFE04 DSR, xFE06 DDR. Every other address maps to RAM[mar[ADDR_W-1:0]]; upper bits are ignored (aliasing wraps).
- FSM states: IDLE, BUSY, DONE.
  - IDLE & mem_en: capture mar, mem_rw, mdr_in. Load cnt = LATENCY-1. Go to BUSY, or straight to DONE if LATENCY=1.
  - BUSY: decrement cnt; at cnt==1 go to DONE.
  - DONE: mem_r=1; mem_data holds the registered read data. Go to IDLE.
- Request inputs are ignored outside IDLE.
- A write commits on the clock edge that ends DONE.
- Read data is registered on the edge entering DONE, using the captured address.
- Register semantics:
  - KBSR read = {ready[15], ie[14], 14'b0}. Writes change bit 14 only.
  - KBDR read = {8'h00, char}. The read clears KBSR[15] at the end of DONE. Writes are ignored.
  - DSR read = {ready[15], ie[14], 14'b0}. Writes change bit 14 only.
  - DDR write: DDR[7:0] = mdr_in[7:0], DSR[15] cleared. DDR read returns 0.
- Keyboard: kb_valid & kb_ready latches kb_data into KBDR and sets KBSR[15].
  - KBSR[15] clear and a new kb_valid in the same cycle: the clear wins. kb_ready is low that cycle; the character is accepted on the next cycle.
- Display: disp_valid & disp_ready sets DSR[15].
  - A DDR write while DSR[15]=0 overwrites DDR. DSR stays 0.

## Timing
- Reset values: state IDLE, mem_r 0, mem_data 0, KBSR x0000, KBDR x0000, DSR x8000, DDR x0000, kb_ready 1, disp_valid 0, kb_irq 0. RAM contents are not reset.
- Latency: if mem_en is first high in IDLE cycle 0, mem_r is high in cycle LATENCY only.
- mem_r is high for one cycle, then IDLE. If mem_en is still high in that IDLE cycle, it starts a new access (back-to-back throughput 1 per LATENCY+1 cycles).
- A read in DONE returns the value committed by any write that finished before it. There is no read/write overlap because accesses are serial.
- Reset asserted mid-access: FSM to IDLE immediately, mem_r low, pending write discarded.
- All status changes take effect on the edge after the triggering cycle.

## Structure
- Package LCp gains:
  - KBSR_ADDR, KBDR_ADDR, DSR_ADDR, DDR_ADDR constants.
  - mem_state_t enum (IDLE, BUSY, DONE).
  - MEM_RD/MEM_WR constants for mem_rw.
- One sub-module: lc3_mmio_regs. It holds the keyboard/display registers, handshakes, and read mux. The top level keeps the FSM, latency counter and RAM.

## Test plan
- RAM write/read, LATENCY=3: write x1234 to x0040, then read x0040 -> mem_r in cycle 3 of each access, mem_data=x1234.
- Alias, ADDR_W=12: write xBEEF to x3040, read x0040 -> xBEEF.
- Keyboard: kb_valid with kb_data=x41 -> KBSR reads x8000, KBDR reads x0041. After the KBDR read, KBSR reads x0000 and kb_ready=1. A second char offered during the clearing cycle is accepted one cycle later.
- Display: write x0158 to DDR -> disp_valid=1, disp_data=x58, DSR reads x0000. disp_ready for one cycle -> DSR=x8000, disp_valid=0.
- Interrupt enable: write xFFFF to KBSR -> KBSR reads x4000. Then a key arrives -> kb_irq=1.
- Reset mid-write in BUSY: mem_r never pulses, target RAM word unchanged, DSR=x8000.
- LATENCY=1: mem_r in cycle 1. Back-to-back with mem_en held high -> mem_r in cycles 1 and 3.
